// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral bus arbiter: width defaults and FSM state type.
package periph_pkg;

    localparam int ADDR_W_DEF = 56;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the request at index ptr has highest priority,
// then ptr+1, ... wrapping at NUM_REQ. Output is one-hot, or zero with no requests.
module rr_arbiter
    import periph_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [2*NUM_REQ-1:0] req2;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   rot_gnt;
    logic [2*NUM_REQ-1:0] gnt2;

    // Rotate so the priority index sits at bit 0, isolate the lowest set bit,
    // then rotate back.
    assign req2    = {req, req} >> ptr;
    assign rot     = req2[NUM_REQ-1:0];
    assign rot_gnt = rot & ((~rot) + NUM_REQ'(1));
    assign gnt2    = {rot_gnt, rot_gnt} << ptr;
    assign grant   = gnt2[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral port among NUM_REQ requesters,
// with a per-transaction ack timeout. All outputs are registered.
module periph_bus_arbiter
    import periph_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        m_req,
    input  logic [NUM_REQ-1:0]        m_we,
    input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
    input  logic [NUM_REQ*DATA_W-1:0] m_wdata,
    output logic [NUM_REQ-1:0]        m_ack,
    output logic [NUM_REQ-1:0]        m_err,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      s_req,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic                      s_ack,
    input  logic [DATA_W-1:0]         s_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 16;

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] win;
    logic [CNT_W-1:0]   cnt;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (m_req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Winner payload mux; ptr_nxt points one past the winner so it ranks last next time.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        ptr_nxt   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = m_we[i];
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
                ptr_nxt   = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            s_req   <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_ack   <= '0;
            m_err   <= '0;
            m_rdata <= '0;
        end else begin
            m_ack <= '0;
            m_err <= '0;
            case (state)
                IDLE: begin
                    if (|m_req) begin
                        s_req   <= 1'b1;
                        s_we    <= sel_we;
                        s_addr  <= sel_addr;
                        s_wdata <= sel_wdata;
                        win     <= grant;
                        ptr     <= ptr_nxt;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // cnt holds completed BUSY cycles; an ack on the expiry cycle still wins.
                    if (s_ack) begin
                        s_req   <= 1'b0;
                        m_rdata <= s_rdata;
                        m_ack   <= win;
                        state   <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        s_req   <= 1'b0;
                        m_rdata <= '0;
                        m_ack   <= win;
                        m_err   <= win;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized scoreboard bench for periph_bus_arbiter: a transaction-level round-robin
// model predicts grant order, payloads, responses and latencies.
module tb_periph_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 56;
    localparam int DW = 128;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_we;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N-1:0]      m_ack;
    logic [N-1:0]      m_err;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_ack;
    logic [DW-1:0]     s_rdata;

    periph_bus_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ack_cyc: BUSY cycle (1-based, >=2) on which the peripheral acks; 0 = never.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            ack_cyc;
        logic [DW-1:0] rd;
    } plan_t;

    typedef struct {
        int            idx;
        logic          err;
        logic [DW-1:0] rd;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];

    logic [N-1:0]  pend;
    int            ptr;
    logic          pay_we[N];
    logic [AW-1:0] pay_addr[N];
    logic [DW-1:0] pay_wdata[N];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    function automatic logic [DW-1:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rnd_a();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[AW-1:0];
    endfunction

    function automatic int rnd_ack();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 0;
        if (r == 2) return TO;
        return $urandom_range(2, TO - 1);
    endfunction

    // Reference rule: first pending index at or after the slot following the last grant.
    function automatic int pick();
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (ptr + off) % N;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic load(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pay_we[i]    = we;
        pay_addr[i]  = a;
        pay_wdata[i] = d;
        m_we[i]      = we;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_req[i]     = 1'b1;
        pend[i]      = 1'b1;
    endtask

    task automatic raise_extra();
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    load(i, 1'($urandom_range(0, 1)), rnd_a(), rnd_w());
        end
    endtask

    // t0 is the IDLE cycle in which the DUT will sample m_req for this grant.
    task automatic do_txn(input int ack_cyc, input logic [DW-1:0] rd, input int t0, input bit extras);
        int    w;
        int    due;
        bit    rose;
        bit    done;
        exp_t  e;
        plan_t p;
        rose = 1'b0;
        done = 1'b0;
        w    = pick();
        ptr  = (w + 1) % N;
        p = '{pay_we[w], pay_addr[w], pay_wdata[w], ack_cyc, rd};
        plan_q.push_back(p);
        e.idx = w;
        e.err = (ack_cyc == 0);
        e.rd  = (ack_cyc == 0) ? '0 : rd;
        exp_q.push_back(e);
        due = t0 + ((ack_cyc == 0) ? TO : ack_cyc) + 1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (s_req && !rose) begin
                rose = 1'b1;
                check("sreq_latency", DW'(cyc), DW'(t0 + 1));
                if (extras) raise_extra();
            end
            if (m_ack != '0) begin
                check("ack_latency", DW'(cyc), DW'(due));
                m_req[w] = 1'b0;
                pend[w]  = 1'b0;
                done     = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no m_ack within 40 cycles, expected at cycle %0d", due);
            finish_run();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_req"},   DW'(s_req),   '0);
        check({tag, "_s_we"},    DW'(s_we),    '0);
        check({tag, "_s_addr"},  DW'(s_addr),  '0);
        check({tag, "_s_wdata"}, s_wdata,      '0);
        check({tag, "_m_ack"},   DW'(m_ack),   '0);
        check({tag, "_m_err"},   DW'(m_err),   '0);
        check({tag, "_m_rdata"}, m_rdata,      '0);
    endtask

    // Peripheral responder: checks the presented payload and acks per plan.
    // Random stray acks while s_req is low must be ignored by the DUT.
    initial begin : periph
        int    pcnt;
        int    lim;
        plan_t cur;
        pcnt    = 0;
        cur     = '{default: 0};
        s_ack   = 1'b0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pcnt  = 0;
                s_ack = 1'b0;
            end else if (s_req) begin
                if (pcnt == 0) begin
                    if (plan_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unplanned_sreq: s_req raised at cycle %0d with no grant expected", cyc);
                        cur = '{default: 0};
                    end else begin
                        cur = plan_q.pop_front();
                    end
                end
                pcnt++;
                check("s_we",    DW'(s_we),   DW'(cur.we));
                check("s_addr",  DW'(s_addr), DW'(cur.addr));
                check("s_wdata", s_wdata,     cur.wdata);
                lim = (cur.ack_cyc != 0) ? cur.ack_cyc : TO;
                check("sreq_hold_len", DW'(pcnt <= lim), DW'(1));
                s_ack   = (pcnt == cur.ack_cyc);
                s_rdata = s_ack ? cur.rd : rnd_w();
            end else begin
                pcnt    = 0;
                s_ack   = ($urandom_range(0, 4) == 0);
                s_rdata = rnd_w();
            end
        end
    end

    // Response monitor: pops the scoreboard whenever any m_ack is seen.
    initial begin : mon
        logic [DW-1:0] last;
        logic [N-1:0]  oh;
        exp_t          e;
        last = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = '0;
            end else if (m_ack != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack: m_ack=%b at cycle %0d with none expected", m_ack, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    oh = N'(1) << e.idx;
                    check("m_ack_grant", DW'(m_ack), DW'(oh));
                    check("m_err",       DW'(m_err), e.err ? DW'(oh) : '0);
                    check("m_rdata",     m_rdata,    e.rd);
                end
                last = m_rdata;
            end else begin
                check("m_err_outside_resp", DW'(m_err), '0);
                check("m_rdata_hold",       m_rdata,    last);
            end
        end
    end

    initial begin : stim
        int n;
        int t0;
        int w;
        bit seen;
        logic [N-1:0] mask;
        rst_n   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        pend    = '0;
        ptr     = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 2 with a one-cycle-ack peripheral.
        load(2, 1'b1, AW'(64'h4000_0000), DW'(128'hA5));
        do_txn(2, rnd_w(), cyc, 1'b0);
        // Read acked on the exact timeout cycle: ack must win.
        load(0, 1'b0, rnd_a(), rnd_w());
        do_txn(TO, DW'(128'hDEAD_BEEF), cyc + 1, 1'b0);
        // Peripheral never acks: timeout path.
        load(1, 1'b1, rnd_a(), rnd_w());
        do_txn(0, rnd_w(), cyc + 1, 1'b0);
        // Full contention.
        for (int i = 0; i < N; i++) load(i, 1'($urandom_range(0, 1)), rnd_a(), rnd_w());
        for (int j = 0; j < N; j++) do_txn(rnd_ack(), rnd_w(), cyc + 1, 1'b0);
        // Fairness: grant 3 alone, then 0 and 3 together.
        load(3, 1'b0, rnd_a(), rnd_w());
        do_txn(2, rnd_w(), cyc + 1, 1'b0);
        load(0, 1'b1, rnd_a(), rnd_w());
        load(3, 1'b1, rnd_a(), rnd_w());
        do_txn(rnd_ack(), rnd_w(), cyc + 1, 1'b0);
        do_txn(rnd_ack(), rnd_w(), cyc + 1, 1'b0);

        // Random traffic with late arrivals during BUSY and idle gaps.
        for (int j = 0; j < 120; j++) begin
            if (pend == '0) begin
                n = $urandom_range(0, 3);
                repeat (n) @(negedge clk);
                mask = N'($urandom_range(1, (1 << N) - 1));
                for (int i = 0; i < N; i++)
                    if (mask[i]) load(i, 1'($urandom_range(0, 1)), rnd_a(), rnd_w());
                t0 = (n == 0) ? cyc + 1 : cyc;
            end else begin
                t0 = cyc + 1;
            end
            do_txn(rnd_ack(), rnd_w(), t0, 1'b1);
        end
        while (pend != '0) do_txn(rnd_ack(), rnd_w(), cyc + 1, 1'b0);

        // Reset mid-BUSY: leave the pointer favouring index 3, then abort it.
        load(1, 1'b0, rnd_a(), rnd_w());
        do_txn(3, rnd_w(), cyc + 1, 1'b0);
        load(0, 1'b1, rnd_a(), rnd_w());
        load(1, 1'b0, rnd_a(), rnd_w());
        load(3, 1'b1, rnd_a(), rnd_w());
        w = pick();
        plan_q.push_back('{pay_we[w], pay_addr[w], pay_wdata[w], 0, '0});
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            seen = s_req;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL reset_setup: s_req never rose before reset test");
            finish_run();
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr   = 0;
        t0    = cyc;
        while (pend != '0) begin
            do_txn(rnd_ack(), rnd_w(), t0, 1'b0);
            t0 = cyc + 1;
        end

        repeat (20) @(negedge clk);
        check("exp_q_drained",  DW'(exp_q.size()),  '0);
        check("plan_q_drained", DW'(plan_q.size()), '0);
        finish_run();
    end

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing the peripheral port.
REQ-002 The module SHALL have parameter ADDR_W, default 56, giving the address width.
REQ-003 The module SHALL have parameter DATA_W, default 128, giving the data width.
REQ-004 The module SHALL have parameter TIMEOUT, default 255, giving the maximum cycles waited for s_ack (range 1..65535).
REQ-005 The ports SHALL be, in this order:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- m_req  in  NUM_REQ  per-requester request level.
- m_we  in  NUM_REQ  per-requester write enable.
- m_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- m_ack  out  NUM_REQ  one-hot completion pulse.
- m_err  out  NUM_REQ  timeout flag, valid with m_ack.
- m_rdata  out  DATA_W  shared read data, valid with m_ack.
- s_req  out  1  request to the peripheral subsystem.
- s_we  out  1  write enable to the peripheral subsystem.
- s_addr  out  ADDR_W  address to the peripheral subsystem.
- s_wdata  out  DATA_W  write data to the peripheral subsystem.
- s_ack  in  1  peripheral completion pulse.
- s_rdata  in  DATA_W  peripheral read data, valid with s_ack.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY and RESP, and all outputs SHALL be registered.
REQ-007 In IDLE with any m_req bit set, the arbiter SHALL pick a winner round-robin, starting at the index after the last granted requester.
REQ-008 On a grant, the arbiter SHALL register the winner's we/addr/wdata onto s_*, assert s_req on the next cycle, and enter BUSY.
REQ-009 In BUSY, s_req and the s_* payload SHALL stay constant until s_ack is sampled high or the timeout fires.
REQ-010 On s_ack in BUSY, the arbiter SHALL:
- deassert s_req on the next cycle;
- latch s_rdata into m_rdata;
- pulse m_ack[winner] for exactly one cycle with m_err=0;
- use the RESP state for that pulse.
REQ-011 On timeout in BUSY (TIMEOUT consecutive BUSY cycles without s_ack), the arbiter SHALL deassert s_req, set m_rdata=0, and pulse m_ack[winner] with m_err[winner]=1 in RESP.
REQ-012 RESP SHALL always return to IDLE, and s_req SHALL be low for at least one cycle between transactions.
REQ-013 Latency SHALL be fixed:
- m_req sampled in IDLE at cycle 0;
- s_req high at cycle 1;
- s_ack at cycle k (k>=2) gives m_ack at cycle k+1;
- for a one-cycle-ack peripheral, request-to-ack is 3 cycles.
REQ-014 Requesters SHALL hold m_req and payload until m_ack and drop m_req on the cycle after m_ack; the arbiter SHALL ignore m_req changes while in BUSY or RESP.
REQ-015 An s_ack arriving in IDLE or RESP SHALL be ignored, with no m_ack generated.
REQ-016 If s_ack and timeout expiry fall on the same cycle, s_ack SHALL win (m_err=0).
REQ-017 After a grant to index NUM_REQ-1, the round-robin pointer SHALL wrap to index 0.
REQ-018 m_ack and m_err SHALL be zero outside RESP, and m_rdata SHALL hold its last value outside RESP.

Reset
REQ-019 While rst_n is low, the block SHALL set:
- state=IDLE;
- s_req=0, s_we=0, s_addr=0, s_wdata=0;
- m_ack=0, m_err=0, m_rdata=0;
- timeout counter=0;
- round-robin pointer such that index 0 has highest priority.
REQ-020 Reset asserted mid-transaction SHALL abandon the transaction with no m_ack, and the first post-reset grant SHALL follow REQ-019 priority.

Structure
REQ-021 The shared package periph_pkg SHALL hold the ADDR_W/DATA_W defaults and the arb_state_t enum (IDLE, BUSY, RESP).
REQ-022 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-023 Single write: m_req[2]=1, we=1, addr=0x4000_0000, wdata=0xA5, one-cycle s_ack -> s_req high cycle 1, m_ack[2] at cycle 3, m_err=0.
REQ-024 Contention: m_req=4'b1111 held (each dropped after its ack) -> grants in order 0,1,2,3, each separated by s_req low for at least one cycle.
REQ-025 Fairness: after grant to 3 with m_req=4'b1001 -> next grant 0, then 3.
REQ-026 Timeout: TIMEOUT=8 and s_ack never asserted -> s_req held 8 cycles, then m_ack[w]=1, m_err[w]=1, m_rdata=0.
REQ-027 Read data plus edge cases: s_ack with s_rdata=0xDEAD_BEEF on the exact timeout cycle -> m_err=0, m_rdata=0xDEAD_BEEF; a stray s_ack in IDLE -> no m_ack.
REQ-028 Reset: rst_n low during BUSY -> all outputs 0 the same cycle, no m_ack after release, and the next grant goes to the lowest requesting index.
